// File: rtl/encoder_pulse_gen_pkg.sv
// Shared types and constants for the encoder pulse generator.
// Quadrature positions follow the Gray sequence 00 -> 10 -> 11 -> 01 (A,B) in the forward direction.
package enc_pkg;
    localparam int SPEED_W        = 7;
    localparam int WINDOW_DEFAULT = 60000;
    localparam int CNT_W_DEFAULT  = 17;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b10;
    localparam logic [1:0] Q2 = 2'b11;
    localparam logic [1:0] Q3 = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [1:0] quad_next(input logic [1:0] q, input logic dir);
        logic [1:0] n;
        n = Q0;
        if (!dir) begin
            case (q)
                Q0:      n = Q1;
                Q1:      n = Q2;
                Q2:      n = Q3;
                default: n = Q0;
            endcase
        end else begin
            case (q)
                Q0:      n = Q3;
                Q3:      n = Q2;
                Q2:      n = Q1;
                default: n = Q0;
            endcase
        end
        return n;
    endfunction
endpackage

// File: rtl/encoder_pulse_gen_if.sv
// Speed command handshake: {speed, dir} offered with valid, accepted when ready.
interface encoder_pulse_gen_if;
    import enc_pkg::*;

    logic [SPEED_W-1:0] cmd_speed;
    logic               cmd_dir;
    logic               cmd_valid;
    logic               cmd_ready;

    modport master (output cmd_speed, output cmd_dir, output cmd_valid, input  cmd_ready);
    modport slave  (input  cmd_speed, input  cmd_dir, input  cmd_valid, output cmd_ready);
endinterface

// File: rtl/encoder_pulse_gen_quad_stepper.sv
// Step-driven output stage: a toggle flop plus a 2-bit Gray quadrature state.
module quad_stepper
    import enc_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic step,
    input  logic dir,
    output logic pulse,
    output logic quad_a,
    output logic quad_b
);
    logic [1:0] quad_q, quad_d;
    logic       pulse_q, pulse_d;

    always_comb begin
        quad_d  = quad_q;
        pulse_d = pulse_q;
        if (step) begin
            quad_d  = quad_next(quad_q, dir);
            pulse_d = ~pulse_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quad_q  <= Q0;
            pulse_q <= 1'b0;
        end else begin
            quad_q  <= quad_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse  = pulse_q;
    assign quad_a = quad_q[1];
    assign quad_b = quad_q[0];
endmodule

// File: rtl/encoder_pulse_gen.sv
// Speed-to-pulse generator: emits active_speed evenly spaced steps per WINDOW-cycle window.
// state | meaning
// IDLE  | counters held at 0, outputs hold their levels; enable high loads any pending command
// RUN   | window counter and step accumulator advance every cycle while enable is high
module encoder_pulse_gen
    import enc_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    encoder_pulse_gen_if.slave cmd,
    output logic               pulse,
    output logic               quad_a,
    output logic               quad_b,
    output logic               window_tick,
    output logic [SPEED_W-1:0] active_speed
);
    localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WINDOW - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   sum;
    logic               tick_q, tick_d;
    logic [SPEED_W-1:0] act_speed_q, act_speed_d;
    logic               act_dir_q, act_dir_d;
    logic               pend_full_q, pend_full_d;
    logic [SPEED_W-1:0] pend_speed_q, pend_speed_d;
    logic               pend_dir_q, pend_dir_d;
    logic               run_go, wrap, boundary, step, xfer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Step spacing: accumulate speed each cycle and step whenever the sum crosses WINDOW.
    always_comb begin
        run_go    = (state_q == RUN) && enable;
        wrap      = run_go && (win_cnt_q == LAST_C);
        boundary  = ((state_q == IDLE) && enable) || wrap;
        sum       = acc_q + CNT_W'(act_speed_q);
        step      = run_go && (sum >= WIN_C);
        win_cnt_d = '0;
        acc_d     = '0;
        if (run_go && !wrap) begin
            win_cnt_d = win_cnt_q + 1'b1;
            acc_d     = step ? (sum - WIN_C) : sum;
        end
        tick_d = (state_d == RUN) && (win_cnt_d == LAST_C);
    end

    // A command arriving on a boundary bypasses the slot so the ready flag never drops.
    always_comb begin
        xfer         = cmd.cmd_valid && !pend_full_q;
        act_speed_d  = act_speed_q;
        act_dir_d    = act_dir_q;
        pend_full_d  = pend_full_q;
        pend_speed_d = pend_speed_q;
        pend_dir_d   = pend_dir_q;
        if (boundary) begin
            if (xfer) begin
                act_speed_d = cmd.cmd_speed;
                act_dir_d   = cmd.cmd_dir;
            end else if (pend_full_q) begin
                act_speed_d = pend_speed_q;
                act_dir_d   = pend_dir_q;
                pend_full_d = 1'b0;
            end
        end else if (xfer) begin
            pend_speed_d = cmd.cmd_speed;
            pend_dir_d   = cmd.cmd_dir;
            pend_full_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_q    <= '0;
            acc_q        <= '0;
            tick_q       <= 1'b0;
            act_speed_q  <= '0;
            act_dir_q    <= 1'b0;
            pend_full_q  <= 1'b0;
            pend_speed_q <= '0;
            pend_dir_q   <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            tick_q       <= tick_d;
            act_speed_q  <= act_speed_d;
            act_dir_q    <= act_dir_d;
            pend_full_q  <= pend_full_d;
            pend_speed_q <= pend_speed_d;
            pend_dir_q   <= pend_dir_d;
        end
    end

    quad_stepper u_stepper (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (step),
        .dir     (act_dir_q),
        .pulse   (pulse),
        .quad_a  (quad_a),
        .quad_b  (quad_b)
    );

    assign cmd.cmd_ready = ~pend_full_q;
    assign window_tick   = tick_q;
    assign active_speed  = act_speed_q;
endmodule

// File: tb/tb_encoder_pulse_gen.sv
// Scoreboard bench: two generators (WINDOW 200 and 127) share stimulus; a window-position model predicts outputs.
module tb_encoder_pulse_gen;
    import enc_pkg::*;

    localparam int W0 = 200;
    localparam int W1 = 127;

    typedef struct packed {
        logic       pulse;
        logic [1:0] quad;
        logic       tick;
        logic [6:0] spd;
        logic       rdy;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] pulse_o, qa_o, qb_o, tick_o;
    logic [6:0] aspd0, aspd1;

    encoder_pulse_gen_if if0 ();
    encoder_pulse_gen_if if1 ();

    always #5 clk = ~clk;

    encoder_pulse_gen #(.WINDOW(W0), .CNT_W(17)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cmd(if0),
        .pulse(pulse_o[0]), .quad_a(qa_o[0]), .quad_b(qb_o[0]),
        .window_tick(tick_o[0]), .active_speed(aspd0)
    );

    encoder_pulse_gen #(.WINDOW(W1), .CNT_W(9)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cmd(if1),
        .pulse(pulse_o[1]), .quad_a(qa_o[1]), .quad_b(qb_o[1]),
        .window_tick(tick_o[1]), .active_speed(aspd1)
    );

    // Reference model: position k within the window, step when floor(s*(k+1)/W) increases.
    int   m_w[2] = '{W0, W1};
    bit   m_run[2], m_dir[2], m_pf[2], m_pd[2], m_pulse[2], m_tick[2];
    int   m_k[2], m_spd[2], m_ps[2], m_qp[2];
    obs_t q0[$], q1[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [1:0] qtab(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic obs_t model_obs(input int i);
        obs_t o;
        o.pulse = m_pulse[i];
        o.quad  = qtab(m_qp[i]);
        o.tick  = m_tick[i];
        o.spd   = 7'(m_spd[i]);
        o.rdy   = !m_pf[i];
        return o;
    endfunction

    function automatic obs_t act_obs(input int i);
        obs_t o;
        if (i == 0) o = {pulse_o[0], qa_o[0], qb_o[0], tick_o[0], aspd0, if0.cmd_ready};
        else        o = {pulse_o[1], qa_o[1], qb_o[1], tick_o[1], aspd1, if1.cmd_ready};
        return o;
    endfunction

    function automatic void check(input string nm, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {pulse,ab,tick,spd,rdy}=%b_%b_%b_%0d_%b expected %b_%b_%b_%0d_%b at %0t",
                     nm, act.pulse, act.quad, act.tick, act.spd, act.rdy,
                     exp.pulse, exp.quad, exp.tick, exp.spd, exp.rdy, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_k[i] = 0; m_spd[i] = 0; m_dir[i] = 0;
            m_pf[i] = 0; m_ps[i] = 0; m_pd[i] = 0;
            m_pulse[i] = 0; m_qp[i] = 0; m_tick[i] = 0;
        end
    endtask

    task automatic model_clock(input bit en, input bit valid, input int spd, input bit dir);
        for (int i = 0; i < 2; i++) begin
            int w;
            bit xfer, bnd, stp, nrun;
            int nk;
            w    = m_w[i];
            xfer = valid && !m_pf[i];
            bnd  = 0;
            stp  = 0;
            if (!m_run[i]) begin
                bnd = en; nrun = en; nk = 0;
            end else if (en) begin
                stp  = ((m_spd[i] * (m_k[i] + 1)) / w) != ((m_spd[i] * m_k[i]) / w);
                bnd  = (m_k[i] == w - 1);
                nrun = 1;
                nk   = bnd ? 0 : m_k[i] + 1;
            end else begin
                nrun = 0; nk = 0;
            end
            if (stp) begin
                m_pulse[i] = !m_pulse[i];
                m_qp[i]    = m_dir[i] ? (m_qp[i] + 3) % 4 : (m_qp[i] + 1) % 4;
            end
            if (bnd) begin
                if (xfer) begin
                    m_spd[i] = spd; m_dir[i] = dir;
                end else if (m_pf[i]) begin
                    m_spd[i] = m_ps[i]; m_dir[i] = m_pd[i]; m_pf[i] = 0;
                end
            end else if (xfer) begin
                m_ps[i] = spd; m_pd[i] = dir; m_pf[i] = 1;
            end
            m_run[i]  = nrun;
            m_k[i]    = nk;
            m_tick[i] = nrun && (nk == w - 1);
        end
    endtask

    task automatic drive(input bit valid, input int spd, input bit dir);
        if0.cmd_valid = valid; if0.cmd_speed = 7'(spd); if0.cmd_dir = dir;
        if1.cmd_valid = valid; if1.cmd_speed = 7'(spd); if1.cmd_dir = dir;
    endtask

    task automatic cyc(input bit en, input bit valid, input int spd, input bit dir);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = en;
        drive(valid, spd, dir);
        model_clock(en, valid, spd, dir);
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
    endtask

    task automatic do_reset();
        obs_t z;
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b0;
        drive(0, 0, 0);
        #1;
        z = '0;
        z.rdy = 1'b1;
        check("async_reset_0", act_obs(0), z);
        check("async_reset_1", act_obs(1), z);
        model_reset();
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cyc(1, 0, 0, 0);
    endtask

    task automatic run_to_k(input int k);
        for (int n = 0; n < 400 && m_k[0] != k; n++) cyc(1, 0, 0, 0);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) check("dut_w200", act_obs(0), q0.pop_front());
            if (q1.size() > 0) check("dut_w127", act_obs(1), q1.pop_front());
        end
    end

    initial begin : stimulus
        drive(0, 0, 0);
        model_reset();
        do_reset();
        do_reset();

        // speed 0: no edges, only window ticks
        run(3 * W0 + 5);

        // speed 10 forward, then 127
        cyc(1, 1, 10, 0);
        run(2 * W0 + 10);
        cyc(1, 1, 127, 0);
        run(2 * W0 + 10);

        // mid-window command swap with a stalled second offer
        cyc(1, 1, 40, 0);
        run_to_k(0);
        run_to_k(50);
        cyc(1, 1, 5, 0);
        for (int c = 0; c < 10; c++) cyc(1, 1, 99, 1);
        run(2 * W0 + 10);

        // reverse direction at a boundary
        cyc(1, 1, 4, 1);
        run(2 * W0 + 10);

        // freeze mid-window, then fresh window on re-enable
        cyc(1, 1, 33, 0);
        run_to_k(0);
        run_to_k(90);
        for (int c = 0; c < 30; c++) cyc(0, 0, 0, 0);
        run(W0 + 20);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit en, vl, dr;
            int sp;
            en = ($urandom_range(0, 99) > 3);
            vl = ($urandom_range(0, 19) == 0);
            dr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       sp = 0;
                1:       sp = 127;
                default: sp = $urandom_range(0, 127);
            endcase
            cyc(en, vl, sp, dr);
        end

        // reset at window position 73
        cyc(1, 1, 60, 1);
        run(W0 + 5);
        run_to_k(73);
        do_reset();
        run(W0 + 10);

        @(negedge clk);
        @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: queues hold %0d/%0d entries, required 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/encoder_pulse_gen.md
Name: encoder_pulse_gen

Overview:
- Speed-to-pulse generator: the transmit-side counterpart of the motor encoder speed measurement.
- Takes a 7-bit speed command plus a direction bit.
- Emits exactly `speed` encoder steps per WINDOW-cycle measurement window, evenly spaced, on a single toggle line (`pulse`) and on quadrature A/B.
- Used as a motor/encoder emulator for closed-loop bring-up and as a stimulus source for speed-measurement logic.

Parameters:
- WINDOW, 60000, clock cycles per measurement window; must be >= 127 (at most one step per cycle).
- CNT_W, 17, width of the window counter and accumulator; must satisfy 2^CNT_W > WINDOW + 127.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run when high; freeze when low
- cmd_speed  in  7  requested steps per window (0..127)
- cmd_dir  in  1  0 = forward, 1 = reverse
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command slot free
- pulse  out  1  toggles once per step (edge count = step count)
- quad_a  out  1  quadrature channel A
- quad_b  out  1  quadrature channel B
- window_tick  out  1  one-cycle strobe on the last cycle of each window
- active_speed  out  7  speed currently being generated

Behaviour:
- Reset (async on reset_n low):
  - pulse, quad_a, quad_b, window_tick, active_speed = 0; active dir = 0.
  - Window counter and accumulator = 0; pending slot empty; cmd_ready = 1.
  - State = IDLE.
- Command handshake:
  - Transfer occurs when cmd_valid && cmd_ready; {speed, dir} is stored in a one-entry pending slot.
  - cmd_ready = !pending_full (registered).
  - A pending command is applied only at a window boundary. At that point active_speed and active dir load from the slot and the slot empties.
  - A transfer in the same cycle as a boundary bypasses the slot: it takes effect for the window that starts next, and cmd_ready stays 1.
- States:
  - IDLE: win_cnt and acc held at 0; pulse and quad outputs hold their levels.
  - IDLE -> RUN on enable = 1. The first RUN cycle is win_cnt = 0 and is treated as a boundary, so any pending command is applied.
  - RUN -> IDLE the cycle after enable = 0 is sampled. No step is generated in that cycle's successor; outputs hold; the partial window is discarded; the pending command is kept.
- RUN, per cycle:
  - win_cnt counts 0..WINDOW-1, then wraps.
  - window_tick is registered high for the cycle in which win_cnt == WINDOW-1.
  - sum = acc + active_speed.
  - If sum >= WINDOW: a step occurs and acc <= sum - WINDOW. Otherwise acc <= sum.
  - At wrap, acc <= 0. The arithmetic then guarantees exactly active_speed steps per window, with the last step on cycle WINDOW-1 when speed > 0.
- Step output:
  - Outputs are registered and change on the clock edge ending the decision cycle (latency 1).
  - pulse toggles on every step.
  - Quadrature state (A,B) advances forward 00 -> 10 -> 11 -> 01 -> 00, or reverse in the opposite order, from the current held state.
- Boundary conditions:
  - Speed 0: no edges at all.
  - Speed 127 with WINDOW = 127: one step every cycle.
  - A direction change never occurs mid-window.
  - Reset mid-window: immediate clear, no partial step.

Decomposition:
- Package enc_pkg:
  - SPEED_W = 7.
  - Quadrature state constants Q0..Q3 and the forward/reverse next-state function.
  - Default WINDOW.
  - State enum IDLE/RUN.
- Sub-module quad_stepper, with inputs clk, reset_n, step, dir and outputs pulse, quad_a, quad_b. It holds the 2-bit Gray-code state and the toggle flop.
- The top level holds the window counter, accumulator, command slot and FSM.

Test Plan:
- WINDOW=200, reset then enable=1, speed 0 -> zero edges on pulse/quad over 3 windows; window_tick high once every 200 cycles.
- WINDOW=200, speed 10, dir 0 -> exactly 10 pulse toggles per window, 20 cycles apart, first on cycle 19 after window start; quad sequence 10, 11, 01, 00, ...
- WINDOW=127, speed 127 -> pulse toggles every cycle; 127 edges per window; acc returns to 0 at wrap.
- Mid-window: speed 40 active, command speed 5 sent at cycle 50 -> current window still delivers 40 steps; cmd_ready low until the boundary; a second cmd_valid stalls; the next window delivers 5 steps and active_speed = 5.
- Direction flip from state 11 at a boundary with speed 4 -> sequence continues 10, 00, 01, 11 (reverse); 4 pulse toggles.
- reset_n low at cycle 73 of a window -> all outputs 0 within the same cycle (async); cmd_ready = 1. enable low mid-window -> outputs frozen at their current levels; on re-enable a full fresh window starts.
